// File: rtl/glitch_sweeper_if.sv
// Control/status bundle between the glitch sweep controller and its user.
interface glitch_sweeper_if #(
    parameter int unsigned CNT_W = 28
) ();
    logic             start;
    logic             abort;
    logic             trig;
    logic             g;
    logic             pow;
    logic             busy;
    logic             done;
    logic             glitch_led;
    logic             boot_led;
    logic [CNT_W-1:0] offset;

    modport master (
        output start, abort, trig,
        input  g, pow, busy, done, glitch_led, boot_led, offset
    );

    modport slave (
        input  start, abort, trig,
        output g, pow, busy, done, glitch_led, boot_led, offset
    );
endinterface

// File: rtl/glitch_sweeper.sv
// Voltage-glitch sweep sequencer: power-cycles the target, waits out boot, optionally
// arms on a trigger edge, fires one glitch per attempt and steps the offset each attempt.
module glitch_sweeper #(
    parameter int unsigned CNT_W        = 28,
    parameter int unsigned BOOT_DELAY   = 24000000,
    parameter int unsigned PWR_OFF_CYC  = 1200000,
    parameter int unsigned OFFSET_START = 12000000,
    parameter int unsigned OFFSET_STEP  = 2,
    parameter int unsigned OFFSET_END   = 12002000,
    parameter int unsigned GLITCH_LEN   = 1500,
    parameter int unsigned TRIG_MODE    = 0,
    parameter int unsigned PWR_CYCLE    = 1,
    parameter int unsigned G_ACTIVE_LOW = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    glitch_sweeper_if.slave  bus
);

    localparam int unsigned      SUM_W       = CNT_W + 1;
    localparam logic [SUM_W-1:0] PWR_OFF_LIM = SUM_W'(PWR_OFF_CYC);
    localparam logic [SUM_W-1:0] BOOT_LIM    = SUM_W'(BOOT_DELAY);
    localparam logic [SUM_W-1:0] GLITCH_LIM  = SUM_W'(GLITCH_LEN);
    localparam logic [SUM_W-1:0] STEP_EXT    = SUM_W'(OFFSET_STEP);
    localparam logic [SUM_W-1:0] END_EXT     = SUM_W'(OFFSET_END);
    localparam logic [CNT_W-1:0] START_VAL   = CNT_W'(OFFSET_START);
    localparam logic             G_IDLE      = 1'(G_ACTIVE_LOW);
    localparam logic             TRIG_EXT    = (TRIG_MODE != 0);
    localparam logic             PWR_EACH    = (PWR_CYCLE != 0);

    typedef enum logic [2:0] {
        S_IDLE, S_PWR_OFF, S_BOOT, S_ARM, S_WAIT, S_GLITCH, S_NEXT, S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] offset_q, offset_nxt;
    logic [1:0]       sync;
    logic             trig_d;
    logic             g_q, g_nxt;
    logic             pow_q, pow_nxt;
    logic             busy_q, busy_nxt;
    logic             done_q, done_nxt;
    logic             gled_q, gled_nxt;
    logic             bled_q, bled_nxt;

    logic [SUM_W-1:0] cnt_inc_c;
    logic [SUM_W-1:0] sum_c;
    logic             step_over_c;
    logic             trig_rise_c;

    // Extra carry bit keeps the offset step from ever wrapping.
    assign cnt_inc_c   = {1'b0, cnt} + SUM_W'(1);
    assign sum_c       = {1'b0, offset_q} + STEP_EXT;
    assign step_over_c = sum_c[CNT_W] || (sum_c > END_EXT);
    assign trig_rise_c = sync[1] & ~trig_d;

    // State register, counters, trigger synchroniser and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            offset_q <= START_VAL;
            sync     <= 2'b00;
            trig_d   <= 1'b0;
            g_q      <= G_IDLE;
            pow_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            gled_q   <= 1'b0;
            bled_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            offset_q <= offset_nxt;
            sync     <= {sync[0], bus.trig};
            trig_d   <= sync[1];
            g_q      <= g_nxt;
            pow_q    <= pow_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;
            gled_q   <= gled_nxt;
            bled_q   <= bled_nxt;
        end
    end

    // Next-state and phase counter.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        case (state)
            S_IDLE, S_DONE: if (bus.start) state_nxt = S_PWR_OFF;
            S_PWR_OFF:      if (cnt_inc_c >= PWR_OFF_LIM) state_nxt = S_BOOT;
            S_BOOT:         if (cnt_inc_c >= BOOT_LIM) state_nxt = S_ARM;
            S_ARM:          if (!TRIG_EXT || trig_rise_c) state_nxt = S_WAIT;
            S_WAIT:         if (cnt_inc_c >= {1'b0, offset_q}) state_nxt = S_GLITCH;
            S_GLITCH:       if (cnt_inc_c >= GLITCH_LIM) state_nxt = S_NEXT;
            S_NEXT:         state_nxt = step_over_c ? S_DONE : (PWR_EACH ? S_PWR_OFF : S_ARM);
            default:        state_nxt = S_IDLE;
        endcase
        if (bus.abort) state_nxt = S_IDLE;
        if ((state_nxt == state) && (state inside {S_PWR_OFF, S_BOOT, S_WAIT, S_GLITCH}))
            cnt_nxt = cnt_inc_c[CNT_W-1:0];
    end

    // Output decode from the upcoming state so every output is a flop.
    always_comb begin
        g_nxt      = (state_nxt == S_GLITCH) ? ~G_IDLE : G_IDLE;
        pow_nxt    = (state_nxt != S_PWR_OFF);
        busy_nxt   = !((state_nxt == S_IDLE) || (state_nxt == S_DONE));
        done_nxt   = (state_nxt == S_DONE);
        bled_nxt   = (state_nxt == S_PWR_OFF) || (state_nxt == S_BOOT);
        gled_nxt   = gled_q;
        offset_nxt = offset_q;
        if (state_nxt == S_NEXT) gled_nxt = 1'b1;
        if ((state == S_ARM) && (state_nxt == S_WAIT)) gled_nxt = 1'b0;
        if (((state == S_IDLE) || (state == S_DONE)) && bus.start) offset_nxt = START_VAL;
        if ((state == S_NEXT) && !step_over_c) offset_nxt = sum_c[CNT_W-1:0];
        if (bus.abort) begin
            gled_nxt   = 1'b0;
            offset_nxt = START_VAL;
        end
    end

    assign bus.g          = g_q;
    assign bus.pow        = pow_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.glitch_led = gled_q;
    assign bus.boot_led   = bled_q;
    assign bus.offset     = offset_q;

endmodule

// File: tb/tb_glitch_sweeper.sv
// Scoreboard bench for glitch_sweeper: four configurations (basic sweep, trigger mode,
// no power cycling, offset near counter limit with active-high glitch).
module tb_glitch_sweeper;

    logic clk;
    logic rst_n;
    int   cyc;
    int   total;
    int   bad;

    typedef struct {
        int unit;
        int at;
        int len;
        int off;
    } glitch_t;

    glitch_t exp_q[$];

    logic        start_d [4];
    logic        abort_d [4];
    logic        trig_d  [4];
    logic        g_s     [4];
    logic        pow_s   [4];
    logic        busy_s  [4];
    logic        done_s  [4];
    logic        gled_s  [4];
    logic        bled_s  [4];
    logic [31:0] off_s   [4];

    localparam logic [3:0] G_AL = 4'b0111;

    glitch_sweeper_if #(.CNT_W(16)) if0 ();
    glitch_sweeper_if #(.CNT_W(16)) if1 ();
    glitch_sweeper_if #(.CNT_W(16)) if2 ();
    glitch_sweeper_if #(.CNT_W(4))  if3 ();

    glitch_sweeper #(.CNT_W(16), .BOOT_DELAY(8), .PWR_OFF_CYC(4), .OFFSET_START(5),
        .OFFSET_STEP(2), .OFFSET_END(9), .GLITCH_LEN(3), .TRIG_MODE(0), .PWR_CYCLE(1),
        .G_ACTIVE_LOW(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    glitch_sweeper #(.CNT_W(16), .BOOT_DELAY(8), .PWR_OFF_CYC(4), .OFFSET_START(5),
        .OFFSET_STEP(2), .OFFSET_END(7), .GLITCH_LEN(3), .TRIG_MODE(1), .PWR_CYCLE(1),
        .G_ACTIVE_LOW(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    glitch_sweeper #(.CNT_W(16), .BOOT_DELAY(8), .PWR_OFF_CYC(4), .OFFSET_START(5),
        .OFFSET_STEP(2), .OFFSET_END(9), .GLITCH_LEN(3), .TRIG_MODE(0), .PWR_CYCLE(0),
        .G_ACTIVE_LOW(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    glitch_sweeper #(.CNT_W(4), .BOOT_DELAY(3), .PWR_OFF_CYC(2), .OFFSET_START(14),
        .OFFSET_STEP(4), .OFFSET_END(15), .GLITCH_LEN(2), .TRIG_MODE(0), .PWR_CYCLE(1),
        .G_ACTIVE_LOW(0)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    assign if0.start = start_d[0];
    assign if1.start = start_d[1];
    assign if2.start = start_d[2];
    assign if3.start = start_d[3];
    assign if0.abort = abort_d[0];
    assign if1.abort = abort_d[1];
    assign if2.abort = abort_d[2];
    assign if3.abort = abort_d[3];
    assign if0.trig  = trig_d[0];
    assign if1.trig  = trig_d[1];
    assign if2.trig  = trig_d[2];
    assign if3.trig  = trig_d[3];

    assign g_s[0] = if0.g;          assign g_s[1] = if1.g;
    assign g_s[2] = if2.g;          assign g_s[3] = if3.g;
    assign pow_s[0] = if0.pow;      assign pow_s[1] = if1.pow;
    assign pow_s[2] = if2.pow;      assign pow_s[3] = if3.pow;
    assign busy_s[0] = if0.busy;    assign busy_s[1] = if1.busy;
    assign busy_s[2] = if2.busy;    assign busy_s[3] = if3.busy;
    assign done_s[0] = if0.done;    assign done_s[1] = if1.done;
    assign done_s[2] = if2.done;    assign done_s[3] = if3.done;
    assign gled_s[0] = if0.glitch_led; assign gled_s[1] = if1.glitch_led;
    assign gled_s[2] = if2.glitch_led; assign gled_s[3] = if3.glitch_led;
    assign bled_s[0] = if0.boot_led;   assign bled_s[1] = if1.boot_led;
    assign bled_s[2] = if2.boot_led;   assign bled_s[3] = if3.boot_led;
    assign off_s[0] = 32'(if0.offset); assign off_s[1] = 32'(if1.offset);
    assign off_s[2] = 32'(if2.offset); assign off_s[3] = 32'(if3.offset);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int u, input int at, input int len, input int off);
        glitch_t e;
        e.unit = u;
        e.at   = at;
        e.len  = len;
        e.off  = off;
        exp_q.push_back(e);
    endtask

    task automatic at_cycle(input int x);
        while (cyc < x) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_pulse(input int u, output int e);
        @(negedge clk);
        start_d[u] = 1'b1;
        e = cyc + 1;
        @(negedge clk);
        start_d[u] = 1'b0;
    endtask

    task automatic chk_idle(input int u, input string tag, input int off_exp);
        check($sformatf("%s_g", tag),      32'(g_s[u]),    32'(G_AL[u]));
        check($sformatf("%s_pow", tag),    32'(pow_s[u]),  32'd1);
        check($sformatf("%s_busy", tag),   32'(busy_s[u]), 32'd0);
        check($sformatf("%s_done", tag),   32'(done_s[u]), 32'd0);
        check($sformatf("%s_gled", tag),   32'(gled_s[u]), 32'd0);
        check($sformatf("%s_bled", tag),   32'(bled_s[u]), 32'd0);
        check($sformatf("%s_offset", tag), off_s[u],       32'(off_exp));
    endtask

    // Monitor: measures each glitch and each pow-low run, compares against the queue.
    bit g_on      [4];
    int g_start   [4];
    int g_len     [4];
    int g_off     [4];
    int plow      [4];
    int plow_runs [4];

    task automatic score(input int u);
        int idx;
        glitch_t e;
        idx = -1;
        for (int i = 0; i < exp_q.size(); i++)
            if (idx < 0 && exp_q[i].unit == u) idx = i;
        if (idx < 0) begin
            total++;
            bad++;
            $display("FAIL u%0d_extra_glitch: got glitch at cycle %0d len %0d expected none",
                     u, g_start[u], g_len[u]);
        end else begin
            e = exp_q[idx];
            exp_q.delete(idx);
            check($sformatf("u%0d_glitch_at", u),  32'(g_start[u]), 32'(e.at));
            check($sformatf("u%0d_glitch_len", u), 32'(g_len[u]),   32'(e.len));
            check($sformatf("u%0d_glitch_off", u), 32'(g_off[u]),   32'(e.off));
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        for (int u = 0; u < 4; u++) begin
            if ((g_s[u] ^ G_AL[u]) === 1'b1) begin
                if (!g_on[u]) begin
                    g_on[u]    = 1'b1;
                    g_start[u] = cyc;
                    g_len[u]   = 1;
                    g_off[u]   = int'(off_s[u]);
                end else begin
                    g_len[u]++;
                end
            end else if (g_on[u]) begin
                g_on[u] = 1'b0;
                score(u);
            end
            if (pow_s[u] === 1'b0) begin
                plow[u]++;
            end else if (plow[u] != 0) begin
                check($sformatf("u%0d_pow_low_len", u), 32'(plow[u]), (u == 3) ? 32'd2 : 32'd4);
                plow_runs[u]++;
                plow[u] = 0;
            end
        end
    end

    initial begin
        int e, e2, r0, r1, dummy;
        total = 0;
        bad   = 0;
        for (int u = 0; u < 4; u++) begin
            start_d[u] = 1'b0;
            abort_d[u] = 1'b0;
            trig_d[u]  = 1'b0;
        end
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle(0, "rst_u0", 5);
        chk_idle(3, "rst_u3", 14);
        rst_n = 1'b1;

        // Basic sweep: offsets 5, 7, 9 with power cycling each attempt.
        start_pulse(0, e);
        push(0, e + 18, 3, 5);
        push(0, e + 42, 3, 7);
        push(0, e + 68, 3, 9);
        at_cycle(e);
        check("a_pow_off_entry", 32'(pow_s[0]),  32'd0);
        check("a_busy_entry",    32'(busy_s[0]), 32'd1);
        at_cycle(e + 21);
        check("a_gled_next", 32'(gled_s[0]), 32'd1);
        at_cycle(e + 30);
        check("a_gled_boot", 32'(gled_s[0]), 32'd1);
        check("a_bled_boot", 32'(bled_s[0]), 32'd1);
        at_cycle(e + 36);
        check("a_gled_wait",   32'(gled_s[0]), 32'd0);
        check("a_bled_wait",   32'(bled_s[0]), 32'd0);
        check("a_offset_att2", off_s[0],       32'd7);
        at_cycle(e + 71);
        check("a_done_early", 32'(done_s[0]), 32'd0);
        at_cycle(e + 72);
        check("a_done",       32'(done_s[0]), 32'd1);
        check("a_busy_done",  32'(busy_s[0]), 32'd0);
        check("a_offset_end", off_s[0],       32'd9);

        // Restart from DONE, ignored start while busy, abort in 2nd glitch cycle.
        start_pulse(0, e2);
        push(0, e2 + 18, 3, 5);
        push(0, e2 + 42, 2, 7);
        at_cycle(e2);
        check("b_restart_offset", off_s[0], 32'd5);
        at_cycle(e2 + 9);
        start_pulse(0, dummy);
        at_cycle(e2 + 43);
        @(negedge clk);
        abort_d[0] = 1'b1;
        @(negedge clk);
        abort_d[0] = 1'b0;
        chk_idle(0, "b_abort", 5);
        @(negedge clk);
        start_d[0] = 1'b1;
        abort_d[0] = 1'b1;
        @(negedge clk);
        start_d[0] = 1'b0;
        abort_d[0] = 1'b0;
        check("b_start_abort_busy", 32'(busy_s[0]), 32'd0);
        check("b_start_abort_pow",  32'(pow_s[0]),  32'd1);

        // Trigger mode: random-phase trig, extra pulses in WAIT/GLITCH ignored.
        start_pulse(1, e);
        at_cycle(e + 14);
        #($urandom_range(1, 7));
        trig_d[1] = 1'b1;
        r0 = cyc;
        push(1, r0 + 8, 3, 5);
        at_cycle(r0 + 5);  trig_d[1] = 1'b0;
        at_cycle(r0 + 6);  trig_d[1] = 1'b1;
        at_cycle(r0 + 9);  trig_d[1] = 1'b0;
        at_cycle(r0 + 10); trig_d[1] = 1'b1;
        at_cycle(r0 + 11); trig_d[1] = 1'b0;
        at_cycle(r0 + 26);
        #($urandom_range(1, 7));
        trig_d[1] = 1'b1;
        r1 = cyc;
        push(1, r1 + 10, 3, 7);
        at_cycle(r1 + 14);
        trig_d[1] = 1'b0;
        check("c_done",   32'(done_s[1]), 32'd1);
        check("c_offset", off_s[1],       32'd7);

        // No power cycling between attempts.
        start_pulse(2, e);
        push(2, e + 18, 3, 5);
        push(2, e + 30, 3, 7);
        push(2, e + 44, 3, 9);
        at_cycle(e + 25);
        check("d_pow_kept", 32'(pow_s[2]), 32'd1);
        at_cycle(e + 47);
        check("d_done_early", 32'(done_s[2]), 32'd0);
        at_cycle(e + 48);
        check("d_done", 32'(done_s[2]), 32'd1);

        // Offset sum carries out of CNT_W: one glitch, then DONE without wrap.
        start_pulse(3, e);
        push(3, e + 20, 2, 14);
        at_cycle(e + 22);
        check("e_done_early", 32'(done_s[3]), 32'd0);
        at_cycle(e + 23);
        check("e_done",   32'(done_s[3]), 32'd1);
        check("e_busy",   32'(busy_s[3]), 32'd0);
        check("e_offset", off_s[3],       32'd14);
        check("e_g_idle", 32'(g_s[3]),    32'd0);

        // Asynchronous reset mid-WAIT and mid-GLITCH.
        start_pulse(0, e);
        at_cycle(e + 15);
        #2 rst_n = 1'b0;
        #1 chk_idle(0, "f_rst_wait", 5);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        start_pulse(0, e);
        push(0, e + 18, 2, 5);
        at_cycle(e + 19);
        #2 rst_n = 1'b0;
        #1 check("f_rst_glitch_g",   32'(g_s[0]),   32'd1);
        check("f_rst_glitch_pow", 32'(pow_s[0]), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("u0_pow_runs", 32'(plow_runs[0]), 32'd7);
        check("u1_pow_runs", 32'(plow_runs[1]), 32'd2);
        check("u2_pow_runs", 32'(plow_runs[2]), 32'd1);
        check("u3_pow_runs", 32'(plow_runs[3]), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/glitch_sweeper.md
# glitch_sweeper

Parametrised voltage-glitch sequencer for fault-injection sweeps. It power-cycles the target, waits out boot, optionally arms on an external trigger edge, then fires one glitch of programmable width at a programmable offset. Each attempt steps the offset until the sweep window is exhausted. It sits between the board clock and the crowbar/glitch driver (`g`) and the target supply switch (`pow`), and supersedes the fixed free-running glitcher.

## Interface
Parameters:
- `CNT_W`, 28, width of every counter and of `offset`
- `BOOT_DELAY`, 24000000, cycles `pow` stays high before arming
- `PWR_OFF_CYC`, 1200000, cycles `pow` is held low per power cycle
- `OFFSET_START`, 12000000, first glitch offset in cycles; must be ≥1
- `OFFSET_STEP`, 2, offset increment per attempt; must be ≥1
- `OFFSET_END`, 12002000, last permitted offset, inclusive
- `GLITCH_LEN`, 1500, glitch width in cycles; must be ≥1
- `TRIG_MODE`, 0: 0 = offset counted from ARM entry; 1 = offset counted from a `trig` rising edge
- `PWR_CYCLE`, 1: 1 = power-cycle before every attempt; 0 = only before the first attempt
- `G_ACTIVE_LOW`, 1: polarity of `g`

Ports:
- `clk` in 1: single clock
- `rst_n` in 1: asynchronous active-low reset
- `start` in 1: synchronous pulse that begins a sweep; ignored while `busy`
- `abort` in 1: synchronous; ends any activity
- `trig` in 1: asynchronous target trigger, synchronised internally
- `g` out 1: glitch drive, registered, polarity per `G_ACTIVE_LOW`
- `pow` out 1: target supply enable, registered, 1 = on
- `busy` out 1: high in every state except IDLE and DONE
- `done` out 1: high in DONE
- `glitch_led` out 1: high for the attempt following a glitch, cleared on entry to WAIT
- `boot_led` out 1: high during PWR_OFF and BOOT
- `offset` out CNT_W: offset of the current or next attempt

## Operation
- States and transitions:
  - IDLE: on `start`, go to PWR_OFF.
  - PWR_OFF: `pow`=0 for PWR_OFF_CYC cycles, then go to BOOT.
  - BOOT: `pow`=1 for BOOT_DELAY cycles, then go to ARM.
  - ARM: with `TRIG_MODE`=0, go to WAIT on the next edge. With `TRIG_MODE`=1, go to WAIT in the cycle a synchronised rising edge is detected.
  - WAIT: counts `offset` cycles, then go to GLITCH.
  - GLITCH: glitch active for GLITCH_LEN cycles, then go to NEXT.
  - NEXT: one cycle. If `offset + OFFSET_STEP` exceeds OFFSET_END, go to DONE. Otherwise `offset` += step, then go to PWR_OFF if `PWR_CYCLE`=1, else ARM.
  - DONE: `start` restarts at `offset`=OFFSET_START and goes to PWR_OFF.
- Arithmetic: the next-offset sum is computed in CNT_W+1 bits. A carry out counts as exceeding OFFSET_END, so the offset never wraps.
- Trigger path: `trig` passes through a 2-FF synchroniser, and the rising edge is taken from the synchronised value. Edges outside ARM are ignored, and at most one glitch fires per attempt.
- `abort` is honoured in every state and takes priority over `start` and state progress. On the next edge: state goes to IDLE, `g` inactive, `pow`=1, `offset`=OFFSET_START, LEDs cleared.
- `start` and `abort` asserted in the same cycle: `abort` wins.
- Reset values, all outputs: `g` inactive (1 when `G_ACTIVE_LOW`=1), `pow`=1, `busy`=0, `done`=0, `glitch_led`=0, `boot_led`=0, `offset`=OFFSET_START, state IDLE, all counters 0.
- Reset asserted mid-glitch: `g` goes inactive immediately (asynchronous), without waiting for a clock edge.

## Timing
- `start` sampled at edge E means PWR_OFF is entered at E, so `pow`=0 and `busy`=1 from E.
- `pow` is low for exactly PWR_OFF_CYC cycles and high for BOOT_DELAY cycles before ARM.
- With `TRIG_MODE`=1 and the edge detected at cycle T (3rd edge after the raw rise), `g` goes active at T+`offset` and stays active for exactly GLITCH_LEN cycles.
- With `TRIG_MODE`=0, `g` goes active `offset`+1 cycles after ARM entry.
- The gap between consecutive glitches with `PWR_CYCLE`=0 is exactly 1 (NEXT) + 1 (ARM) + `offset`.
- `offset` updates at the NEXT exit edge and is stable throughout each attempt.
- DONE is entered one cycle after the last glitch ends, and `done` is high from that cycle.

## Test plan
- Small parameters (PWR_OFF_CYC=4, BOOT_DELAY=8, OFFSET_START=5, STEP=2, END=9, GLITCH_LEN=3, `TRIG_MODE`=0, `PWR_CYCLE`=1), one `start` pulse -> exactly 3 glitches at offsets 5, 7, 9; each glitch 3 cycles wide; `pow` low 4 cycles before each attempt; then `done`=1 and `busy`=0.
- `TRIG_MODE`=1, `trig` rising at a random phase -> `g` active exactly 2+1+`offset` cycles after the raw rise; extra `trig` pulses during WAIT/GLITCH produce no second glitch.
- `abort` asserted in the 2nd GLITCH cycle -> next edge: `g` inactive, `pow`=1, state IDLE, `offset`=OFFSET_START.
- OFFSET_START=2^CNT_W−2, STEP=4, END=2^CNT_W−1 -> single glitch, then DONE with no wrap.
- `rst_n` low mid-WAIT and mid-GLITCH -> all outputs at their reset values without a clock edge; `start` while `busy` -> ignored; `start` in DONE -> new sweep from OFFSET_START.
- `PWR_CYCLE`=0 -> `pow` stays high after the first BOOT; glitch spacing matches the Timing formula.
